// File: rtl/preamble_sync_ctrl.sv
// -----------------------------------------------------------------------------
// preamble_sync_ctrl
//
// Sequencer for the preamble detector datapath (CIC decimator, moving-average
// autocorrelation, peak detect).
//
// Arms the detector and issues a one-cycle clear to its pipeline. It then
// masks peaks until the moving averages have filled (SETTLE_LEN decimated
// samples). On an accepted peak it optionally waits CAP_OFFSET samples, then
// opens a capture window of CAP_LEN decimated samples. After the window it
// either returns to IDLE or, in continuous mode, holds off for HOLDOFF samples
// and re-arms.
//
// Ports:
//   clk          in   1          clock
//   reset_n      in   1          asynchronous reset, active-low
//   arm          in   1          pulse: start the sequence (only honoured in IDLE)
//   abort        in   1          pulse: return to IDLE from any state
//   cont         in   1          level: re-arm after HOLDOFF instead of stopping
//   timeout_len  in   CNT_WIDTH  max decimated samples in WAIT_PEAK, 0 = none
//   samp_stb     in   1          decimated sample strobe from the detector
//   peak_stb     in   1          peak strobe from the detector
//   det_clear    out  1          one-cycle clear to the detector datapath
//   cap_en       out  1          capture gate; a sample is captured on
//                                cap_en && samp_stb
//   cap_last     out  1          marks the final captured sample; it rises once
//                                only the last strobe of the window is pending,
//                                so cap_last && samp_stb is the final capture
//   timeout_stb  out  1          one-cycle pulse when WAIT_PEAK times out
//   busy         out  1          state != IDLE
//   state        out  3          current FSM state
//   det_count    out  16         saturating count of accepted peaks
//
// All outputs are registered: each is computed from the next state and
// counter value, so it is aligned with the state it describes.
//
// CAP_LEN must be at least 1.
// -----------------------------------------------------------------------------
module preamble_sync_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int SETTLE_LEN = 4092,
    parameter int CAP_OFFSET = 0,
    parameter int CAP_LEN    = 1024,
    parameter int HOLDOFF    = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 cont,
    input  logic [CNT_WIDTH-1:0] timeout_len,
    input  logic                 samp_stb,
    input  logic                 peak_stb,
    output logic                 det_clear,
    output logic                 cap_en,
    output logic                 cap_last,
    output logic                 timeout_stb,
    output logic                 busy,
    output logic [2:0]           state,
    output logic [15:0]          det_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_SETTLE  = 3'd2,
        S_WAIT    = 3'd3,
        S_OFFSET  = 3'd4,
        S_CAPTURE = 3'd5,
        S_HOLDOFF = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_LEN);
    localparam logic [CNT_WIDTH-1:0] OFFSET_LOAD = CNT_WIDTH'(CAP_OFFSET);
    localparam logic [CNT_WIDTH-1:0] CAP_LOAD    = CNT_WIDTH'(CAP_LEN);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLDOFF);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [15:0]          det_count_q, det_count_d;
    logic                 det_clear_q, det_clear_d;
    logic                 cap_en_q, cap_en_d;
    logic                 cap_last_q, cap_last_d;
    logic                 timeout_stb_q, timeout_stb_d;
    logic                 busy_q, busy_d;

    logic                 count_done;
    logic                 timeout_hit;
    logic                 peak_take;

    // Length loaded into the shared down-counter when a state is entered.
    function automatic logic [CNT_WIDTH-1:0] entry_len(
        input state_t                 s,
        input logic [CNT_WIDTH-1:0]   tlen
    );
        case (s)
            S_SETTLE:  entry_len = SETTLE_LOAD;
            S_WAIT:    entry_len = tlen;
            S_OFFSET:  entry_len = OFFSET_LOAD;
            S_CAPTURE: entry_len = CAP_LOAD;
            S_HOLDOFF: entry_len = HOLD_LOAD;
            default:   entry_len = '0;
        endcase
    endfunction

    // Peak counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A counted state is finished when it was entered with length 0 (exit on
    // the next cycle) or when the strobe that brings the count to zero arrives.
    assign count_done  = (cnt_q == '0) || (samp_stb && (cnt_q == CNT_ONE));

    // In WAIT_PEAK a loaded value of 0 means no timeout: the counter then sits
    // at 0 and never reaches the "one strobe left" condition.
    assign timeout_hit = samp_stb && (cnt_q == CNT_ONE);

    assign peak_take   = (state_q == S_WAIT) && !abort && peak_stb;

    // -------------------------------------------------------------------------
    // State register (plus counter, peak count and registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            det_count_q   <= '0;
            det_clear_q   <= 1'b0;
            cap_en_q      <= 1'b0;
            cap_last_q    <= 1'b0;
            timeout_stb_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            det_count_q   <= det_count_d;
            det_clear_q   <= det_clear_d;
            cap_en_q      <= cap_en_d;
            cap_last_q    <= cap_last_d;
            timeout_stb_q <= timeout_stb_d;
            busy_q        <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    // Peaks are meaningless until the averages are full.
                    if (count_done) state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A peak on the same cycle as timeout expiry wins.
                    if (peak_stb) begin
                        state_d = (CAP_OFFSET == 0) ? S_CAPTURE : S_OFFSET;
                    end else if (timeout_hit) begin
                        state_d = cont ? S_CLEAR : S_IDLE;
                    end
                end
                S_OFFSET: begin
                    if (count_done) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (count_done) state_d = cont ? S_HOLDOFF : S_IDLE;
                end
                S_HOLDOFF: begin
                    if (!cont) begin
                        state_d = S_IDLE;
                    end else if (count_done) begin
                        state_d = S_CLEAR;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Counter and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d         = cnt_q;
        det_count_d   = det_count_q;
        det_clear_d   = 1'b0;
        cap_en_d      = 1'b0;
        cap_last_d    = 1'b0;
        timeout_stb_d = 1'b0;
        busy_d        = 1'b0;

        // Every transition changes state, so a change of state is an entry
        // and reloads the shared counter.
        if (state_d != state_q) begin
            cnt_d = entry_len(state_d, timeout_len);
        end else if (samp_stb && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        if (peak_take) begin
            det_count_d = sat_inc(det_count_q);
        end

        det_clear_d   = (state_d == S_CLEAR);
        cap_en_d      = (state_d == S_CAPTURE);
        cap_last_d    = (state_d == S_CAPTURE) && (cnt_d == CNT_ONE);
        timeout_stb_d = (state_q == S_WAIT) && !abort && !peak_stb && timeout_hit;
        busy_d        = (state_d != S_IDLE);
    end

    assign state       = state_q;
    assign det_count   = det_count_q;
    assign det_clear   = det_clear_q;
    assign cap_en      = cap_en_q;
    assign cap_last    = cap_last_q;
    assign timeout_stb = timeout_stb_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_preamble_sync_ctrl.sv
module tb_preamble_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        arm, abort, cont, samp_stb, peak_stb;
    logic [15:0] timeout_len;

    logic        det_clear0, cap_en0, cap_last0, timeout_stb0, busy0;
    logic [2:0]  state0;
    logic [15:0] det_count0;
    logic        det_clear1, cap_en1, cap_last1, timeout_stb1, busy1;
    logic [2:0]  state1;
    logic [15:0] det_count1;
    logic [23:0] obs0, obs1;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    // Reference model: state number, strobes seen in it, its length, peaks.
    int ms   [2];
    int mn   [2];
    int mlen [2];
    int mcnt [2];
    bit mto  [2];

    localparam int P_SET  [2] = '{4092, 5};
    localparam int P_OFF  [2] = '{0, 3};
    localparam int P_CAP  [2] = '{1024, 4};
    localparam int P_HOLD [2] = '{256, 2};

    always #5 clk = ~clk;

    assign obs0 = {det_clear0, cap_en0, cap_last0, timeout_stb0, busy0, state0, det_count0};
    assign obs1 = {det_clear1, cap_en1, cap_last1, timeout_stb1, busy1, state1, det_count1};

    preamble_sync_ctrl dut0 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .cont(cont),
        .timeout_len(timeout_len), .samp_stb(samp_stb), .peak_stb(peak_stb),
        .det_clear(det_clear0), .cap_en(cap_en0), .cap_last(cap_last0),
        .timeout_stb(timeout_stb0), .busy(busy0), .state(state0), .det_count(det_count0)
    );

    preamble_sync_ctrl #(
        .CNT_WIDTH(16), .SETTLE_LEN(5), .CAP_OFFSET(3), .CAP_LEN(4), .HOLDOFF(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .cont(cont),
        .timeout_len(timeout_len), .samp_stb(samp_stb), .peak_stb(peak_stb),
        .det_clear(det_clear1), .cap_en(cap_en1), .cap_last(cap_last1),
        .timeout_stb(timeout_stb1), .busy(busy1), .state(state1), .det_count(det_count1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_enter(input int k, input int s);
        ms[k] = s;
        mn[k] = 0;
        case (s)
            2:       mlen[k] = P_SET[k];
            3:       mlen[k] = int'(timeout_len);
            4:       mlen[k] = P_OFF[k];
            5:       mlen[k] = P_CAP[k];
            6:       mlen[k] = P_HOLD[k];
            default: mlen[k] = 0;
        endcase
    endtask

    task automatic m_step(input int k);
        bit done;
        mto[k] = 1'b0;
        done = (mlen[k] == 0) || (samp_stb && (mn[k] + 1 == mlen[k]));
        if (abort) m_enter(k, 0);
        else begin
            case (ms[k])
                0: if (arm) m_enter(k, 1);
                1: m_enter(k, 2);
                2: if (done) m_enter(k, 3); else if (samp_stb) mn[k]++;
                3: begin
                    if (peak_stb) begin
                        mcnt[k] = (mcnt[k] < 65535) ? mcnt[k] + 1 : 65535;
                        m_enter(k, (P_OFF[k] == 0) ? 5 : 4);
                    end else if (mlen[k] != 0 && samp_stb && (mn[k] + 1 == mlen[k])) begin
                        mto[k] = 1'b1;
                        m_enter(k, cont ? 1 : 0);
                    end else if (samp_stb) mn[k]++;
                end
                4: if (done) m_enter(k, 5); else if (samp_stb) mn[k]++;
                5: if (done) m_enter(k, cont ? 6 : 0); else if (samp_stb) mn[k]++;
                6: begin
                    if (!cont) m_enter(k, 0);
                    else if (done) m_enter(k, 1);
                    else if (samp_stb) mn[k]++;
                end
                default: m_enter(k, 0);
            endcase
        end
    endtask

    function automatic logic [23:0] m_exp(input int k);
        m_exp = {(ms[k] == 1), (ms[k] == 5), (ms[k] == 5 && mn[k] == mlen[k] - 1),
                 mto[k], (ms[k] != 0), 3'(ms[k]), 16'(mcnt[k])};
    endfunction

    // Model update on the same edges as the DUT.
    initial begin
        for (int k = 0; k < 2; k++) begin
            ms[k] = 0; mn[k] = 0; mlen[k] = 0; mcnt[k] = 0; mto[k] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    ms[k] = 0; mn[k] = 0; mlen[k] = 0; mcnt[k] = 0; mto[k] = 1'b0;
                end else begin
                    m_step(k);
                end
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("cyc_dut0", 32'(obs0), 32'(m_exp(0)));
                chk("cyc_dut1", 32'(obs1), 32'(m_exp(1)));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic bit rs();
        rs = ($urandom_range(7, 0) != 0);
    endfunction

    // Apply inputs (called at posedge+1) and advance one clock.
    task automatic drive(input bit a, input bit ab, input bit s, input bit p);
        arm = a; abort = ab; samp_stb = s; peak_stb = p;
        @(posedge clk);
        #1;
    endtask

    // Random strobes until dut0 reaches tgt; counts strobes seen in state cs.
    task automatic run_until(input int tgt, input int cs, input string nm, output int n);
        int b;
        bit s;
        n = 0;
        b = 0;
        while (int'(state0) != tgt && b < 20000) begin
            s = rs();
            if (s && int'(state0) == cs) n++;
            drive(1'b0, 1'b0, s, (state0 == 3'd3) ? 1'b0 : ($urandom_range(3, 0) == 0));
            b++;
        end
        chk(nm, 32'(state0), 32'(tgt));
    endtask

    initial begin
        int  n, b, ncap, nlast, lastat;
        bit  s;
        logic [15:0] exp_cnt;

        reset_n = 1'b0; arm = 1'b0; abort = 1'b0; cont = 1'b0;
        samp_stb = 1'b0; peak_stb = 1'b0; timeout_len = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dut0", 32'(obs0), 32'd0);
        chk("rst_dut1", 32'(obs1), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_on = 1'b1;

        // Arm, then settle with strobes and peaks held high.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_clear", {29'd0, state0}, 32'd1);
        chk("t1_det_clear", 32'(det_clear0), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1_settle", {28'd0, det_clear0, state0}, 32'd2);
        n = 0;
        while (state0 == 3'd2 && n < 5000) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            n++;
        end
        chk("t1_settle_len", 32'(n), 32'd4092);
        chk("t1_wait", 32'(state0), 32'd3);
        chk("t1_no_det", 32'(det_count0), 32'd0);
        chk("t1_model_state", 32'(ms[0]), 32'd3);

        // Peak in WAIT_PEAK, single capture.
        drive(1'b0, 1'b0, rs(), 1'b1);
        chk("t2_det_count", 32'(det_count0), 32'd1);
        chk("t2_capture", 32'(state0), 32'd5);
        chk("t2_model_cnt", 32'(mcnt[0]), 32'd1);
        ncap = 0; nlast = 0; lastat = 0; b = 0;
        while (busy0 && b < 5000) begin
            s = rs();
            if (cap_en0 && s) begin
                ncap++;
                if (cap_last0) begin nlast++; lastat = ncap; end
            end
            drive(1'b0, 1'b0, s, $urandom_range(1, 0) == 1);
            b++;
        end
        chk("t2_cap_strobes", 32'(ncap), 32'd1024);
        chk("t2_last_count", 32'(nlast), 32'd1);
        chk("t2_last_at", 32'(lastat), 32'd1024);
        chk("t2_idle", {28'd0, busy0, state0}, 32'd0);

        // Timeout after 10 WAIT_PEAK strobes, cont=0 then cont=1.
        timeout_len = 16'd10;
        for (int c = 0; c < 2; c++) begin
            cont = (c == 1);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            run_until(3, 2, "t3_reach_wait", n);
            chk("t3_settle_len", 32'(n), 32'd4092);
            n = 0; b = 0;
            while (state0 == 3'd3 && b < 200) begin
                s = rs();
                if (s) n++;
                drive(1'b0, 1'b0, s, 1'b0);
                b++;
            end
            chk("t3_to_strobes", 32'(n), 32'd10);
            chk("t3_to_stb", 32'(timeout_stb0), 32'd1);
            chk("t3_to_state", {28'd0, det_clear0, state0}, (c == 1) ? 32'h9 : 32'h0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk("t3_to_pulse_end", 32'(timeout_stb0), 32'd0);
            chk("t3_after", 32'(state0), (c == 1) ? 32'd2 : 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_abort", 32'(state0), 32'd0);

        // Continuous mode: repeated captures, holdoff, saturation.
        timeout_len = 16'd0;
        cont = 1'b1;
        exp_cnt = 16'd2;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk("t4_settle", 32'(state0), 32'd2);
            if (r == 1) begin
                force dut0.det_count_q = 16'hFFFE;
                mcnt[0] = 32'hFFFE;
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                release dut0.det_count_q;
                exp_cnt = 16'hFFFF;
            end
            run_until(3, 2, "t4_reach_wait", n);
            drive(1'b0, 1'b0, rs(), 1'b1);
            chk("t4_det_count", 32'(det_count0), 32'(exp_cnt));
            run_until(6, 5, "t4_reach_holdoff", n);
            chk("t4_cap_strobes", 32'(n), 32'd1024);
            if (r < 2) begin
                run_until(1, 6, "t4_rearm", n);
                chk("t4_holdoff_len", 32'(n), 32'd256);
                chk("t4_rearm_clear", 32'(det_clear0), 32'd1);
            end else begin
                for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
                chk("t4_in_holdoff", 32'(state0), 32'd6);
                cont = 1'b0;
                drive(1'b0, 1'b0, 1'b1, 1'b0);
                chk("t4_cont_drop", {28'd0, busy0, state0}, 32'd0);
            end
        end
        chk("t4_sat", 32'(det_count0), 32'hFFFF);

        // Abort mid-capture, arm+abort in IDLE, async reset mid-SETTLE.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_arm_abort", 32'(state0), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run_until(3, 2, "t5_reach_wait", n);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        ncap = 0; b = 0;
        while (ncap < 499 && b < 5000) begin
            s = rs();
            if (cap_en0 && s) ncap++;
            drive(1'b0, 1'b0, s, 1'b0);
            b++;
        end
        chk("t5_pre_abort", 32'(state0), 32'd5);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_abort", {27'd0, cap_en0, cap_last0, state0}, 32'd0);
        chk("t5_abort_busy", 32'(busy0), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_mid_settle", 32'(state0), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_rst0", 32'(obs0), 32'd0);
        chk("t5_async_rst1", 32'(obs1), 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Peak coincident with timeout expiry; arm while busy.
        timeout_len = 16'd10;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_arm_busy", {28'd0, det_clear0, state0}, 32'd2);
        run_until(3, 2, "t6_reach_wait", n);
        n = 0; b = 0;
        while (n < 9 && b < 200) begin
            s = rs();
            if (s) n++;
            drive(1'b0, 1'b0, s, 1'b0);
            b++;
        end
        chk("t6_still_wait", 32'(state0), 32'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_capture", 32'(state0), 32'd5);
        chk("t6_no_timeout", 32'(timeout_stb0), 32'd0);
        chk("t6_det_count", 32'(det_count0), 32'd1);
        chk("t6_model_to", 32'(mto[0]), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_arm_in_cap", 32'(state0), 32'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_abort", 32'(state0), 32'd0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
